// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the level-tracking FIFO.
// Latency: n/a (elaboration-time functions only).
// Backpressure: n/a.
package fifo_pkg;

  // Number of entries addressed by an addr_width-bit pointer.
  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // Occupancy needs one extra bit so that a completely full FIFO is representable.
  function automatic int level_width(input int addr_width);
    return addr_width + 1;
  endfunction

  // Thresholds must sit inside the occupancy range for the flags to ever toggle.
  function automatic bit thresh_legal(input int depth, input int afull, input int aempty);
    return (afull >= 1) && (afull <= depth) && (aempty >= 0) && (aempty <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage for fifo_level: one write port, one async read port.
// Latency: write lands on the clock edge; read data is combinational from r_addr.
// Backpressure: none; the controller decides when we is asserted.
module fifo_mem #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] w_addr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic [ADDR_WIDTH-1:0] r_addr,
  output logic [DATA_WIDTH-1:0] r_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Store the write word; contents are deliberately never cleared.
  always_ff @(posedge clk) begin
    if (we) mem[w_addr] <= w_data;
  end

  assign r_data = mem[r_addr];

endmodule

// File: rtl/fifo_level.sv
// Single-clock FIFO with occupancy, almost-full/empty thresholds, flush and sticky error flags.
// Latency: 1 cycle write-to-visible; FIFO_FWFT_EN selects head-presented read data, else registered pop data.
// Backpressure: full rejects writes unless a read is accepted in the same cycle; flags come from registered level only.
module fifo_level
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH    = 3,
  parameter int DATA_WIDTH    = 8,
  parameter int AFULL_THRESH  = fifo_depth(ADDR_WIDTH) - 1,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int LW    = level_width(ADDR_WIDTH);

  typedef logic [LW-1:0] level_t;

  if (!thresh_legal(DEPTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_thresh
    $error("fifo_level: AFULL_THRESH/AEMPTY_THRESH outside legal range");
  end

  logic [ADDR_WIDTH-1:0] w_ptr, r_ptr;
  level_t                level_q;
  logic                  ovf_q, udf_q;
  logic                  wr_ok, rd_ok;
  logic [DATA_WIDTH-1:0] head_data;

  // A pop frees a slot, so a full FIFO still accepts a write alongside a read.
  assign rd_ok = rd && !empty;
  assign wr_ok = wr && (!full || rd_ok);

  fifo_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk    (clk),
    .we     (!reset && !flush && wr_ok),
    .w_addr (w_ptr),
    .w_data (w_data),
    .r_addr (r_ptr),
    .r_data (head_data)
  );

  // Pointers, occupancy and sticky errors; reset beats flush beats traffic.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      w_ptr   <= '0;
      r_ptr   <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (wr_ok) w_ptr <= w_ptr + ADDR_WIDTH'(1);
      if (rd_ok) r_ptr <= r_ptr + ADDR_WIDTH'(1);
      if (wr_ok && !rd_ok)      level_q <= level_q + level_t'(1);
      else if (rd_ok && !wr_ok) level_q <= level_q - level_t'(1);
      if (wr && !wr_ok) ovf_q <= 1'b1;
      if (rd && !rd_ok) udf_q <= 1'b1;
    end
  end

  assign level        = level_q;
  assign full         = (level_q == level_t'(DEPTH));
  assign empty        = (level_q == '0);
  assign almost_full  = (level_q >= level_t'(AFULL_THRESH));
  assign almost_empty = (level_q <= level_t'(AEMPTY_THRESH));
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

`ifdef FIFO_FWFT_EN
  // Head entry is shown directly; forced to zero while empty so reset reads back 0.
  assign r_data = empty ? '0 : head_data;
`else
  logic [DATA_WIDTH-1:0] r_q;

  // Capture the head on an accepted pop and hold it otherwise (flush leaves it alone).
  always_ff @(posedge clk) begin
    if (reset)               r_q <= '0;
    else if (!flush && rd_ok) r_q <= head_data;
  end

  assign r_data = r_q;
`endif

endmodule

// File: tb/tb_fifo_level.sv
module tb_fifo_level;

  localparam int AW     = 3;
  localparam int DW     = 8;
  localparam int DEPTH  = 8;
  localparam int AFULL  = DEPTH - 1;
  localparam int AEMPTY = 1;

  logic          clk = 1'b0;
  logic          reset, flush, wr, rd;
  logic [DW-1:0] w_data;
  logic [DW-1:0] r_data;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;
  logic [AW:0]   level;

  int checks = 0;
  int errors = 0;

  // Reference state: contents as a queue plus the observable sticky flags.
  logic [DW-1:0] q[$];
  logic          m_ovf, m_udf;
  logic [DW-1:0] m_rdata;
  bit            m_fresh;  // empty since reset, before any write

  fifo_level #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .AFULL_THRESH  (AFULL),
    .AEMPTY_THRESH (AEMPTY)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .wr           (wr),
    .w_data       (w_data),
    .rd           (rd),
    .r_data       (r_data),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus at the falling edge, advance the model at the
  // rising edge, and compare every output at the next falling edge.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                      input logic f, input logic rs);
    int  n;
    bit  rok, wok;
    wr = w; w_data = d; rd = r; flush = f; reset = rs;
    @(posedge clk);
    n = q.size();
    if (rs) begin
      q.delete(); m_ovf = 0; m_udf = 0; m_rdata = '0; m_fresh = 1;
    end else if (f) begin
      q.delete(); m_ovf = 0; m_udf = 0;
    end else begin
      rok = r && (n > 0);
      wok = w && ((n < DEPTH) || rok);
      if (r && !rok) m_udf = 1;
      if (w && !wok) m_ovf = 1;
      if (rok) m_rdata = q.pop_front();
      if (wok) begin q.push_back(d); m_fresh = 0; end
    end
    @(negedge clk);
    n = q.size();
    check("level",        32'(level),        32'(n));
    check("full",         32'(full),         32'(n == DEPTH));
    check("empty",        32'(empty),        32'(n == 0));
    check("almost_full",  32'(almost_full),  32'(n >= AFULL));
    check("almost_empty", 32'(almost_empty), 32'(n <= AEMPTY));
    check("overflow",     32'(overflow),     32'(m_ovf));
    check("underflow",    32'(underflow),    32'(m_udf));
`ifdef FIFO_FWFT_EN
    if (n > 0)        check("r_data_head", 32'(r_data), 32'(q[0]));
    else if (m_fresh) check("r_data_rst",  32'(r_data), 32'h0);
`else
    check("r_data", 32'(r_data), 32'(m_rdata));
`endif
  endtask

  initial begin
    int aa_pos;
    reset = 1; flush = 0; wr = 0; rd = 0; w_data = '0;
    q.delete(); m_ovf = 0; m_udf = 0; m_rdata = '0; m_fresh = 1;
    @(negedge clk);

    // Reset state
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 1);

    // Fill stepwise to full, then push a 9th word that must be dropped
    for (int i = 0; i < DEPTH; i++) step(1, 8'h10 + 8'(i), 0, 0, 0);
    step(1, 8'h99, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    check("ovf_sticky", 32'(overflow), 32'h1);

    // Drain in order, then read once more while empty
    for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 1, 0, 0);
    check("udf_after_drain", 32'(underflow), 32'h0);
    step(0, 8'h00, 1, 0, 0);
    check("udf_empty_read", 32'(underflow), 32'h1);

    // Simultaneous write/read while full; 0xAA is the 8th word out
    for (int i = 0; i < DEPTH; i++) step(1, 8'h30 + 8'(i), 0, 0, 0);
    step(1, 8'hAA, 1, 0, 0);
    check("full_wr_rd_level", 32'(level), 32'(DEPTH));
`ifdef FIFO_FWFT_EN
    aa_pos = DEPTH - 1;
`else
    aa_pos = DEPTH;
`endif
    for (int i = 0; i < aa_pos; i++) step(0, 8'h00, 1, 0, 0);
    check("aa_eighth_read", 32'(r_data), 32'hAA);
    while (q.size() > 0) step(0, 8'h00, 1, 0, 0);

    // Flush with a concurrent write: nothing lands, flags clear
    for (int i = 0; i < 5; i++) step(1, 8'h50 + 8'(i), 0, 0, 0);
    step(1, 8'hEE, 0, 1, 0);
    step(1, 8'h61, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
`ifndef FIFO_FWFT_EN
    check("post_flush_read", 32'(r_data), 32'h61);
`endif

    // Pointer wrap at steady level 3
    for (int i = 0; i < 3; i++) step(1, 8'h70 + 8'(i), 0, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 8'h80 + 8'(i), 1, 0, 0);

    // Randomised traffic with rate-biased phases, rare flush and reset
    for (int ph = 0; ph < 12; ph++) begin
      int wp = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 30 : 55;
      for (int c = 0; c < 60; c++) begin
        logic w, r, f, rs;
        w  = ($urandom_range(99) < wp);
        r  = ($urandom_range(99) < 100 - wp);
        f  = ($urandom_range(59) == 0);
        rs = ($urandom_range(199) == 0);
        step(w, 8'($urandom), r, f, rs);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
